sn74_modcnt: RTL and testbench



---
 rtl/sn74_modcnt.sv | 109 ++++++++++
 tb/tb_sn74_modcnt.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sn74_modcnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sn74_modcnt                                                |
// | Description : Synchronous modulo-N counter with 161/163-style load,      |
// |               P/T enables and ripple-carry cascade, 93-style R0/R1       |
// |               gated clear, registered wrap pulse. Async active-low       |
// |               clear on clr_n.                                            |
// |               Optional up/down counting when SN_CNT_UPDOWN_EN is         |
// |               defined (adds the dn input).                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sn74_modcnt #(
  parameter int     WIDTH   = 4,
  parameter longint MODULUS = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             r0,
  input  logic             r1,
  input  logic             load_n,
  input  logic [WIDTH-1:0] d,
  input  logic             enp,
  input  logic             ent,
`ifdef SN_CNT_UPDOWN_EN
  input  logic             dn,
`endif
  output logic [WIDTH-1:0] q,
  output logic             rco,
  output logic             wrap
);

  // Highest legal count value; also the wrap target when counting down.
  localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MODULUS - 64'sd1);
  localparam logic [63:0]      c_MOD = 64'(MODULUS);

  // Reject impossible configurations at elaboration.
  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("sn74_modcnt: WIDTH must be in 1..32");
    end
    if (MODULUS < 2 || MODULUS > (64'sd1 <<< WIDTH)) begin : g_bad_modulus
      $error("sn74_modcnt: MODULUS must be in 2..2**WIDTH");
    end
  endgenerate

  logic             w_dn;
  logic [WIDTH-1:0] w_term;
  logic [WIDTH-1:0] w_wrap_to;
  logic             w_at_term;
  logic             w_d_ok;
  logic [63:0]      w_d_ext;

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             wrap_q;
  logic             wrap_d;

`ifdef SN_CNT_UPDOWN_EN
  assign w_dn = dn;
`else
  assign w_dn = 1'b0;
`endif

  // Terminal count and wrap destination follow the current direction.
  assign w_term    = w_dn ? '0    : c_MAX;
  assign w_wrap_to = w_dn ? c_MAX : '0;
  assign w_at_term = (cnt_q == w_term);

  // Out-of-range load data is replaced by 0 so q never leaves 0..MODULUS-1.
  assign w_d_ext = 64'(d);
  assign w_d_ok  = (w_d_ext < c_MOD);

  // Next-state: gated clear > load > count > hold.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (r0 && r1) begin
      cnt_d = '0;
    end else if (!load_n) begin
      cnt_d = w_d_ok ? d : '0;
    end else if (enp && ent) begin
      if (w_at_term) begin
        cnt_d  = w_wrap_to;
        wrap_d = 1'b1;
      end else if (w_dn) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Count and wrap registers; clr_n clears them without waiting for clk.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = cnt_q;
  assign wrap = wrap_q;
  assign rco  = ent & w_at_term;

endmodule
`default_nettype wire

// File: tb/tb_sn74_modcnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sn74_modcnt                                             |
// | Description : Self-checking bench for sn74_modcnt: mod-16 and mod-10     |
// |               instances on a shared stimulus bus, a two-stage mod-10     |
// |               cascade, and (with SN_CNT_UPDOWN_EN) a mod-12 up/down      |
// |               instance.                                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sn74_modcnt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus bus
  logic       clr_n, r0, r1, load_n, enp, ent;
  logic [3:0] d;
`ifdef SN_CNT_UPDOWN_EN
  logic       dn;
`endif

  logic [3:0] q16, q10;
  logic       rco16, rco10, wrap16, wrap10;
`ifdef SN_CNT_UPDOWN_EN
  logic [3:0] q12;
  logic       rco12, wrap12;
`endif

  // Cascade
  logic       cclr_n, cenp;
  logic [3:0] cq0, cq1;
  logic       crco0, crco1, cwrap0, cwrap1;

  sn74_modcnt #(.WIDTH(4), .MODULUS(16)) u_dut16 (
    .clk(clk), .clr_n(clr_n), .r0(r0), .r1(r1), .load_n(load_n), .d(d),
    .enp(enp), .ent(ent),
`ifdef SN_CNT_UPDOWN_EN
    .dn(dn),
`endif
    .q(q16), .rco(rco16), .wrap(wrap16));

  sn74_modcnt #(.WIDTH(4), .MODULUS(10)) u_dut10 (
    .clk(clk), .clr_n(clr_n), .r0(r0), .r1(r1), .load_n(load_n), .d(d),
    .enp(enp), .ent(ent),
`ifdef SN_CNT_UPDOWN_EN
    .dn(dn),
`endif
    .q(q10), .rco(rco10), .wrap(wrap10));

`ifdef SN_CNT_UPDOWN_EN
  sn74_modcnt #(.WIDTH(4), .MODULUS(12)) u_dut12 (
    .clk(clk), .clr_n(clr_n), .r0(r0), .r1(r1), .load_n(load_n), .d(d),
    .enp(enp), .ent(ent), .dn(dn),
    .q(q12), .rco(rco12), .wrap(wrap12));
`endif

  sn74_modcnt #(.WIDTH(4), .MODULUS(10)) u_cas0 (
    .clk(clk), .clr_n(cclr_n), .r0(1'b0), .r1(1'b0), .load_n(1'b1), .d(4'd0),
    .enp(cenp), .ent(1'b1),
`ifdef SN_CNT_UPDOWN_EN
    .dn(1'b0),
`endif
    .q(cq0), .rco(crco0), .wrap(cwrap0));

  sn74_modcnt #(.WIDTH(4), .MODULUS(10)) u_cas1 (
    .clk(clk), .clr_n(cclr_n), .r0(1'b0), .r1(1'b0), .load_n(1'b1), .d(4'd0),
    .enp(cenp), .ent(crco0),
`ifdef SN_CNT_UPDOWN_EN
    .dn(1'b0),
`endif
    .q(cq1), .rco(crco1), .wrap(cwrap1));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         dut;
    string      tag;
    logic [3:0] q;
    logic       rco;
    logic       wrap;
  } exp_t;

  typedef struct {
    logic       r0, r1, load_n;
    logic [3:0] d;
    logic       enp, ent;
    logic [3:0] q;
    logic       rco, wrap;
  } vec_t;

  exp_t sb[$];
  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp(input exp_t e);
    logic [3:0] aq;
    logic       ar, aw;
    aq = 'x; ar = 1'bx; aw = 1'bx;
    case (e.dut)
      0: begin aq = q16; ar = rco16; aw = wrap16; end
      1: begin aq = q10; ar = rco10; aw = wrap10; end
`ifdef SN_CNT_UPDOWN_EN
      2: begin aq = q12; ar = rco12; aw = wrap12; end
`endif
      default: ;
    endcase
    chk({e.tag, " q"},    32'(aq), 32'(e.q));
    chk({e.tag, " rco"},  32'(ar), 32'(e.rco));
    chk({e.tag, " wrap"}, 32'(aw), 32'(e.wrap));
  endtask

  // Push expectation, let one rising edge happen, then pop and compare.
  task automatic edge_check(input int dut, input string tag,
                            input logic [3:0] eq, input logic er, input logic ew);
    exp_t e;
    e.dut = dut; e.tag = tag; e.q = eq; e.rco = er; e.wrap = ew;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cmp(sb.pop_front());
  endtask

  task automatic set_in(input logic ir0, input logic ir1, input logic ild,
                        input logic [3:0] id, input logic ienp, input logic ient);
    r0 = ir0; r1 = ir1; load_n = ild; d = id; enp = ienp; ent = ient;
  endtask

  function automatic vec_t v(input logic a0, input logic a1, input logic ld,
                             input logic [3:0] dd, input logic p, input logic t,
                             input logic [3:0] eq, input logic er, input logic ew);
    vec_t x;
    x.r0 = a0; x.r1 = a1; x.load_n = ld; x.d = dd; x.enp = p; x.ent = t;
    x.q = eq; x.rco = er; x.wrap = ew;
    return x;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wcount;
    // Mod-10 vectors: r0 r1 load_n d enp ent -> q rco wrap
    tv.push_back(v(0,0,0, 7,1,1, 7,0,0));  // load beats count
    tv.push_back(v(0,0,1, 0,1,1, 8,0,0));
    tv.push_back(v(0,0,1, 0,1,1, 9,1,0));
    tv.push_back(v(0,0,1, 0,1,1, 0,0,1));
    tv.push_back(v(0,0,1, 0,1,1, 1,0,0));
    tv.push_back(v(0,0,1, 0,1,1, 2,0,0));
    tv.push_back(v(0,0,0,12,1,1, 0,0,0));  // d >= MODULUS
    tv.push_back(v(0,0,0, 9,0,1, 9,1,0));  // loaded terminal -> rco
    tv.push_back(v(0,0,0,10,1,1, 0,0,0));  // d == MODULUS
    tv.push_back(v(0,0,0,15,0,1, 0,0,0));
    tv.push_back(v(0,0,0, 5,1,1, 5,0,0));
    tv.push_back(v(1,0,1, 0,1,1, 6,0,0));  // one leg only
    tv.push_back(v(0,1,1, 0,1,1, 7,0,0));
    tv.push_back(v(1,1,0, 5,1,1, 0,0,0));  // clear beats load
    tv.push_back(v(0,0,1, 0,1,1, 1,0,0));
    tv.push_back(v(0,0,1, 0,1,0, 1,0,0));  // ent low holds
    tv.push_back(v(0,0,1, 0,0,1, 1,0,0));  // enp low holds
    tv.push_back(v(0,0,0, 9,1,1, 9,1,0));
    tv.push_back(v(1,1,1, 0,1,1, 0,0,0));  // clear beats wrap
    tv.push_back(v(0,0,0, 9,0,0, 9,0,0));  // ent gates rco
    tv.push_back(v(0,0,1, 0,1,1, 0,0,1));
    tv.push_back(v(0,0,1, 0,0,1, 0,0,0));  // wrap is one cycle

    clr_n = 1'b1; cclr_n = 1'b1; cenp = 1'b0;
    set_in(0, 0, 1, 4'd0, 0, 1);
`ifdef SN_CNT_UPDOWN_EN
    dn = 1'b0;
`endif
    #2;
    clr_n = 1'b0; cclr_n = 1'b0;
    #1;
    chk("reset q16",    32'(q16),    32'd0);
    chk("reset wrap16", 32'(wrap16), 32'd0);
    chk("reset rco16",  32'(rco16),  32'd0);
    chk("reset q10",    32'(q10),    32'd0);

    // Clear held low across an edge with load and count requested
    @(negedge clk);
    set_in(0, 0, 0, 4'd5, 1, 1);
    edge_check(0, "hold-in-clear", 4'd0, 1'b0, 1'b0);

    // Mod-16 free run
    @(negedge clk);
    clr_n = 1'b1;
    set_in(0, 0, 1, 4'd0, 1, 1);
    for (int k = 1; k <= 20; k++) begin
      edge_check(0, $sformatf("m16 k%0d", k), 4'(k % 16), (k % 16) == 15, k == 16);
    end

    // Mod-10 vector table
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      set_in(tv[i].r0, tv[i].r1, tv[i].load_n, tv[i].d, tv[i].enp, tv[i].ent);
      edge_check(1, $sformatf("vec%0d", i), tv[i].q, tv[i].rco, tv[i].wrap);
    end

    // Async clear pulse at q=6, then resume
    @(negedge clk);
    set_in(0, 0, 0, 4'd5, 1, 1);
    edge_check(1, "pre-clr load", 4'd5, 1'b0, 1'b0);
    @(negedge clk);
    set_in(0, 0, 1, 4'd0, 1, 1);
    edge_check(1, "pre-clr count", 4'd6, 1'b0, 1'b0);
    chk("pre-clr q16", 32'(q16), 32'd6);
    #2;
    clr_n = 1'b0;
    #1;
    chk("async clr q10",  32'(q10),  32'd0);
    chk("async clr q16",  32'(q16),  32'd0);
    chk("async clr w10",  32'(wrap10), 32'd0);
    clr_n = 1'b1;
    edge_check(1, "resume1", 4'd1, 1'b0, 1'b0);
    chk("resume1 q16", 32'(q16), 32'd1);
    edge_check(1, "resume2", 4'd2, 1'b0, 1'b0);

    // Async clear while wrap is high
    @(negedge clk);
    set_in(0, 0, 0, 4'd9, 1, 1);
    edge_check(1, "load9", 4'd9, 1'b1, 1'b0);
    @(negedge clk);
    set_in(0, 0, 1, 4'd0, 1, 1);
    edge_check(1, "wrap before clr", 4'd0, 1'b0, 1'b1);
    #2;
    clr_n = 1'b0;
    #1;
    chk("async clr wrap10", 32'(wrap10), 32'd0);
    chk("async clr q16b",   32'(q16),    32'd0);
    clr_n = 1'b1;

    // Two-stage mod-10 cascade
    @(negedge clk);
    cclr_n = 1'b1; cenp = 1'b1;
    wcount = 0;
    for (int k = 1; k <= 105; k++) begin
      @(posedge clk);
      #1;
      if (cwrap1 === 1'b1) wcount++;
      chk($sformatf("cas k%0d", k), 32'(cq1) * 10 + 32'(cq0), 32'(k % 100));
      if (k == 99) chk("cas rco1@99", 32'(crco1), 32'd1);
      if (k == 100) chk("cas wrap1@100", 32'(cwrap1), 32'd1);
    end
    chk("cas wrap1 pulses", 32'(wcount), 32'd1);
    chk("cas q1@105", 32'(cq1), 32'd0);
    chk("cas q0@105", 32'(cq0), 32'd5);

`ifdef SN_CNT_UPDOWN_EN
    // Mod-12 up/down
    @(negedge clk);
    dn = 1'b1;
    set_in(0, 0, 0, 4'd1, 1, 1);
    edge_check(2, "ud load1", 4'd1, 1'b0, 1'b0);
    @(negedge clk);
    set_in(0, 0, 1, 4'd0, 1, 1);
    edge_check(2, "ud dn1", 4'd0, 1'b1, 1'b0);
    edge_check(2, "ud dn2", 4'd11, 1'b0, 1'b1);
    edge_check(2, "ud dn3", 4'd10, 1'b0, 1'b0);
    @(negedge clk);
    dn = 1'b0;
    edge_check(2, "ud up1", 4'd11, 1'b1, 1'b0);
    @(negedge clk);
    enp = 1'b0; dn = 1'b1;
    #1;
    chk("ud rco follows dn=1", 32'(rco12), 32'd0);
    dn = 1'b0;
    #1;
    chk("ud rco follows dn=0", 32'(rco12), 32'd1);
    enp = 1'b1;
    edge_check(2, "ud up2", 4'd0, 1'b0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
